// File: rtl/finv_pkg.sv
// Shared definitions for the reciprocal Newton-Raphson refinement stage.
//   FRAC_DEF     : default fraction width of the internal Q1.FRAC format
//   ITER_DEF     : default number of Newton iterations
//   q1_t         : Q1.FRAC unsigned fixed-point word at the default width
//   finv_state_t : refinement FSM states
package finv_pkg;

  localparam int unsigned FRAC_DEF = 26;
  localparam int unsigned ITER_DEF = 2;

  typedef logic [FRAC_DEF:0] q1_t;

  typedef enum logic [1:0] {
    StIdle,
    StMulT,
    StMulR,
    StOut
  } finv_state_t;

endpackage

// File: rtl/finv_newton_if.sv
// Request/response bundle of the reciprocal refinement stage.
//   x, y0  : operand and its table seed (requester -> stage)
//   ready  : request strobe (requester -> stage)
//   busy   : stage occupied (stage -> requester)
//   valid  : one-cycle result strobe (stage -> requester)
//   y      : registered reciprocal (stage -> requester)
interface finv_newton_if;

  logic [31:0] x;
  logic [31:0] y0;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [31:0] y;

  modport master (
    output x,
    output y0,
    output ready,
    input  busy,
    input  valid,
    input  y
  );

  modport slave (
    input  x,
    input  y0,
    input  ready,
    output busy,
    output valid,
    output y
  );

endinterface

// File: rtl/finv_fxmul.sv
// Combinational unsigned Q1.FRAC x Q1.FRAC multiplier, truncating to Q1.FRAC.
//   a_i, b_i : Q1.FRAC operands
//   p_o      : product truncated to Q1.FRAC (integer bit 1 dropped)
//   ovf_o    : product >= 2.0, i.e. not representable in Q1.FRAC
module finv_fxmul
  import finv_pkg::*;
#(
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic [FRAC:0] a_i,
  input  logic [FRAC:0] b_i,
  output logic [FRAC:0] p_o,
  output logic          ovf_o
);

  logic [2*FRAC+1:0] prod;
  logic [FRAC-1:0]   unused_lsb;

  always_comb begin
    prod       = {{(FRAC + 1){1'b0}}, a_i} * {{(FRAC + 1){1'b0}}, b_i};
    p_o        = prod[2*FRAC:FRAC];
    ovf_o      = prod[2*FRAC+1];
    unused_lsb = prod[FRAC-1:0];
  end

endmodule

// File: rtl/finv_newton.sv
// Newton-Raphson refinement of a reciprocal seed: r <- r * (2 - mx * r),
// ITER iterations on one shared Q1.FRAC multiplier, then repacked as an
// IEEE-754 single using the seed's sign and exponent.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : request (x, y0, ready) / response (busy, valid, y) bundle
module finv_newton
  import finv_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  finv_newton_if.slave  bus
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  // Distance between the 23-bit IEEE mantissa LSB and the Q1.FRAC LSB.
  localparam int unsigned Pad  = FRAC - 23;

  finv_state_t   state_q;
  logic [CntW-1:0] cnt_q;
  logic [FRAC:0] mx_q, r_q, t_q;
  logic          t_ovf_q;
  logic [31:0]   y0_q, y_q;
  logic          bypass_q, valid_q, busy_q;

  logic [FRAC:0]   mx_in, r0_in;
  logic            bypass_in;
  logic            unused_xsign;
  logic [FRAC+1:0] c_full;
  logic [FRAC:0]   c;
  logic [FRAC:0]   mul_a, mul_b, mul_p;
  logic            mul_ovf;
  logic [22:0]     mant;
  logic [31:0]     y_new;

  // Operand decode: mx in [1,2), r0 = seed significand / 2 in [0.5,1).
  always_comb begin
    mx_in        = (FRAC + 1)'({1'b1, bus.x[22:0]}) << Pad;
    r0_in        = ((FRAC + 1)'({1'b1, bus.y0[22:0]}) << Pad) >> 1;
    // Zero exponent or exact power of two: the seed is already the answer.
    bypass_in    = (bus.x[30:23] == 8'd0) || (bus.x[22:0] == 23'd0);
    unused_xsign = bus.x[31];
  end

  // c = 2 - t in FRAC+2 bits; t >= 2 clamps to 0, t == 0 saturates below 2.
  always_comb begin
    c_full = {2'b10, {FRAC{1'b0}}} - {1'b0, t_q};
    if (t_ovf_q) begin
      c = '0;
    end else if (c_full[FRAC+1]) begin
      c = '1;
    end else begin
      c = c_full[FRAC:0];
    end
  end

  // Shared multiplier: mx*r while forming t, r*c while updating r.
  always_comb begin
    mul_a = mx_q;
    mul_b = r_q;
    if (state_q == StMulR) begin
      mul_a = r_q;
      mul_b = c;
    end
  end

  finv_fxmul #(
    .FRAC (FRAC)
  ) u_fxmul (
    .a_i   (mul_a),
    .b_i   (mul_b),
    .p_o   (mul_p),
    .ovf_o (mul_ovf)
  );

  // Result packing: mantissa sits below the leading 1 at weight 2^-1.
  always_comb begin
    mant  = r_q[FRAC] ? '1 : r_q[FRAC-2 -: 23];
    y_new = bypass_q ? y0_q : {y0_q[31:23], mant};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mx_q     <= '0;
      r_q      <= '0;
      t_q      <= '0;
      t_ovf_q  <= 1'b0;
      y0_q     <= '0;
      y_q      <= '0;
      bypass_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (bus.ready) begin
            mx_q     <= mx_in;
            r_q      <= r0_in;
            y0_q     <= bus.y0;
            bypass_q <= bypass_in;
            cnt_q    <= '0;
            state_q  <= StMulT;
          end
        end
        StMulT: begin
          busy_q  <= 1'b1;
          t_q     <= mul_p;
          t_ovf_q <= mul_ovf;
          state_q <= StMulR;
        end
        StMulR: begin
          busy_q <= 1'b1;
          // r*c >= 2 only for a corrupt seed; pin r high so the mantissa saturates.
          r_q    <= mul_ovf ? '1 : mul_p;
          if (cnt_q == CntW'(ITER - 1)) begin
            state_q <= StOut;
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
            state_q <= StMulT;
          end
        end
        StOut: begin
          busy_q  <= 1'b1;
          valid_q <= 1'b1;
          y_q     <= y_new;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.y     = y_q;

endmodule

// File: tb/tb_finv_newton.sv
// Directed vectors, multi-cycle corner sequences and a random sweep for finv_newton.
module tb_finv_newton;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  finv_newton_if bif ();

  finv_newton #(
    .ITER (2),
    .FRAC (26)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bif)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y0;
    logic [31:0] ey;
    int          tol;
  } vec_t;

  vec_t vecs[8];

  // Compare as raw integers; tol is the allowed distance in ulp.
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input int tol);
    longint d;
    checks++;
    d = longint'({32'd0, act}) - longint'({32'd0, exp});
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      errors++;
      $display("FAIL %s: got %08h, want %08h (tol %0d)", name, act, exp, tol);
    end
  endtask

  // Issue one request from idle; returns result, cycles from acceptance edge
  // to valid, and busy sampled after each edge (bit k = after edge k).
  task automatic run_op(input logic [31:0] xv, input logic [31:0] y0v,
                        output logic [31:0] yv, output int lat, output logic [31:0] bmask);
    bif.x     = xv;
    bif.y0    = y0v;
    bif.ready = 1'b1;
    @(posedge clk); #1;
    bif.ready = 1'b0;
    lat       = 0;
    bmask     = '0;
    bmask[0]  = bif.busy;
    while (!bif.valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      bmask[lat] = bif.busy;
    end
    yv = bif.y;
  endtask

  // Seed = 2/mx truncated to 6 mantissa bits; reference = correctly rounded 1/x.
  function automatic void make_vec(input logic [31:0] xv, output logic [31:0] seed,
                                   output logic [31:0] ref_y);
    logic [63:0] m, qt, qr;
    logic [7:0]  ey;
    m     = {40'd0, 1'b1, xv[22:0]};
    qt    = (64'd1 << 47) / m;
    qr    = ((64'd1 << 47) + (m >> 1)) / m;
    ey    = 8'(9'd253 - {1'b0, xv[30:23]});
    seed  = {xv[31], ey, qt[22:17], 17'd0};
    ref_y = {xv[31], ey, qr[22:0]};
  endfunction

  initial begin
    logic [31:0] yv, bm, sd, rf, xv;
    logic [31:0] ya, yb;
    logic [12:0] vmask;
    int          lat, nvalid;

    vecs[0] = '{x: 32'h40400000, y0: 32'h3EA80000, ey: 32'h3EAAAAAB, tol: 2};  // 3.0
    vecs[1] = '{x: 32'h40000000, y0: 32'h3F000000, ey: 32'h3F000000, tol: 0};  // 2.0 bypass
    vecs[2] = '{x: 32'h00000000, y0: 32'h00000000, ey: 32'h00000000, tol: 0};  // zero
    vecs[3] = '{x: 32'hBFC00000, y0: 32'hBF280000, ey: 32'hBF2AAAAB, tol: 2};  // -1.5
    vecs[4] = '{x: 32'h00400000, y0: 32'h12345678, ey: 32'h12345678, tol: 0};  // e==0 passthrough
    vecs[5] = '{x: 32'h3FA00000, y0: 32'h3F4C0000, ey: 32'h3F4CCCCD, tol: 2};  // 1.25
    vecs[6] = '{x: 32'h3F800001, y0: 32'h3F7FFFFF, ey: 32'h3F7FFFFE, tol: 2};  // mx just above 1
    vecs[7] = '{x: 32'h3FFFFFFF, y0: 32'h3F000000, ey: 32'h3F000001, tol: 2};  // mx just below 2

    rstn      = 1'b0;
    bif.x     = '0;
    bif.y0    = '0;
    bif.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset valid", {31'd0, bif.valid}, 32'd0, 0);
    check32("reset busy", {31'd0, bif.busy}, 32'd0, 0);
    check32("reset y", bif.y, 32'd0, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x, vecs[i].y0, yv, lat, bm);
      check32($sformatf("vec%0d latency", i), 32'(lat), 32'd5, 0);
      check32($sformatf("vec%0d busy", i), bm, 32'h0000003E, 0);
      check32($sformatf("vec%0d y", i), yv, vecs[i].ey, vecs[i].tol);
    end

    // ready held high: A accepted at 0, junk in cycles 1-5 ignored, B accepted at 6.
    bif.x     = 32'h40400000;
    bif.y0    = 32'h3EA80000;
    bif.ready = 1'b1;
    @(posedge clk); #1;
    vmask     = '0;
    vmask[0]  = bif.valid;
    ya        = '0;
    yb        = '0;
    bif.x     = 32'h40800000;
    bif.y0    = 32'h11111111;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      vmask[k] = bif.valid;
      if (k == 5) begin
        ya     = bif.y;
        bif.x  = 32'h40000000;
        bif.y0 = 32'h3F000000;
      end
      if (k == 11) begin
        yb        = bif.y;
        bif.ready = 1'b0;
      end
    end
    check32("b2b valid pattern", {19'd0, vmask}, 32'h00000820, 0);
    check32("b2b first y", ya, 32'h3EAAAAAB, 2);
    check32("b2b second y", yb, 32'h3F000000, 0);

    // Reset in cycle 3 of an operation aborts with no late valid.
    bif.x     = 32'h3FA00000;
    bif.y0    = 32'h3F4C0000;
    bif.ready = 1'b1;
    @(posedge clk); #1;
    bif.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check32("abort valid", {31'd0, bif.valid}, 32'd0, 0);
    check32("abort busy", {31'd0, bif.busy}, 32'd0, 0);
    check32("abort y", bif.y, 32'd0, 0);
    @(posedge clk); #1;
    rstn   = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bif.valid) nvalid++;
    end
    check32("abort no pulse", 32'(nvalid), 32'd0, 0);
    run_op(32'h3FA00000, 32'h3F4C0000, yv, lat, bm);
    check32("post-reset latency", 32'(lat), 32'd5, 0);
    check32("post-reset y", yv, 32'h3F4CCCCD, 2);

    // Random normal operands with 6-bit seeds.
    for (int i = 0; i < 10000; i++) begin
      xv[31]    = 1'($urandom_range(1, 0));
      xv[30:23] = 8'($urandom_range(250, 2));
      xv[22:0]  = 23'($urandom);
      if (xv[22:0] == 23'd0) xv[22:0] = 23'd1;
      make_vec(xv, sd, rf);
      run_op(xv, sd, yv, lat, bm);
      check32($sformatf("sweep x=%08h", xv), yv, rf, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
